// File: rtl/writeback_regfile.sv
// Writeback register file: 31 x 32-bit registers, r0 hard-wired to zero,
// two combinational read ports with optional same-cycle write forwarding.
module writeback_regfile #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_read_data_buffered,
  input  logic [31:0] alu_result_buffered,
  input  logic [4:0]  write_reg_addr_buffered,
  input  logic        reg_write_buffered,
  input  logic        mem_reg_buffered,
  input  logic [4:0]  read_addr_a,
  input  logic [4:0]  read_addr_b,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b,
  output logic [31:0] wb_data
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic        wr_en;
  logic [31:0] stored_a;
  logic [31:0] stored_b;

  always_comb begin
    wb_data = mem_reg_buffered ? mem_read_data_buffered : alu_result_buffered;
  end

  // Writes to r0 are dropped here, so r0 never needs storage.
  always_comb begin
    wr_en = (reg_write_buffered == 1'b1) && (write_reg_addr_buffered != 5'd0);
  end

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (write_reg_addr_buffered == 5'(i))) begin
        regs_d[i] = wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    stored_a = 32'h0000_0000;
    stored_b = 32'h0000_0000;
    for (int i = 1; i < 32; i++) begin
      if (read_addr_a == 5'(i)) begin
        stored_a = regs_q[i];
      end
      if (read_addr_b == 5'(i)) begin
        stored_b = regs_q[i];
      end
    end
  end

  // Reads are forced to zero while in reset, which also masks forwarding.
  always_comb begin
    read_data_a = stored_a;
    read_data_b = stored_b;
    if (!rst_n) begin
      read_data_a = 32'h0000_0000;
      read_data_b = 32'h0000_0000;
    end else if (BYPASS_EN) begin
      if (wr_en && (read_addr_a == write_reg_addr_buffered)) begin
        read_data_a = wb_data;
      end
      if (wr_en && (read_addr_b == write_reg_addr_buffered)) begin
        read_data_b = wb_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile; one forwarding and one
// non-forwarding instance share the same stimulus.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_data;
  logic [31:0] alu_data;
  logic [4:0]  waddr;
  logic        reg_write;
  logic        mem_reg;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rda_byp, rdb_byp, wb_byp;
  logic [31:0] rda_nob, rdb_nob, wb_nob;

  int n_cmp;
  int n_mis;
  logic [31:0] exp_regs [0:31];

  writeback_regfile #(.BYPASS_EN(1'b1)) u_dut_byp (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .mem_read_data_buffered  (mem_data),
    .alu_result_buffered     (alu_data),
    .write_reg_addr_buffered (waddr),
    .reg_write_buffered      (reg_write),
    .mem_reg_buffered        (mem_reg),
    .read_addr_a             (raddr_a),
    .read_addr_b             (raddr_b),
    .read_data_a             (rda_byp),
    .read_data_b             (rdb_byp),
    .wb_data                 (wb_byp)
  );

  writeback_regfile #(.BYPASS_EN(1'b0)) u_dut_nob (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .mem_read_data_buffered  (mem_data),
    .alu_result_buffered     (alu_data),
    .write_reg_addr_buffered (waddr),
    .reg_write_buffered      (reg_write),
    .mem_reg_buffered        (mem_reg),
    .read_addr_a             (raddr_a),
    .read_addr_b             (raddr_b),
    .read_data_a             (rda_nob),
    .read_data_b             (rdb_nob),
    .wb_data                 (wb_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data, input logic use_mem);
    reg_write = 1'b1;
    waddr     = addr;
    mem_reg   = use_mem;
    if (use_mem) begin
      mem_data = data;
      alu_data = ~data;
    end else begin
      alu_data = data;
      mem_data = ~data;
    end
    step();
    reg_write = 1'b0;
    if (addr != 5'd0) exp_regs[addr] = data;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      check_val({tag, "_a_byp"}, rda_byp, exp_regs[i]);
      check_val({tag, "_b_byp"}, rdb_byp, exp_regs[31 - i]);
      check_val({tag, "_a_nob"}, rda_nob, exp_regs[i]);
      check_val({tag, "_b_nob"}, rdb_nob, exp_regs[31 - i]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    rst_n     = 1'b0;
    mem_data  = 32'h0000_0022;
    alu_data  = 32'h0000_0011;
    waddr     = 5'd3;
    reg_write = 1'b1;
    mem_reg   = 1'b1;
    raddr_a   = 5'd3;
    raddr_b   = 5'd3;
    #12;
    // in reset: wb_data still selects, reads forced to zero, write ignored
    check_val("rst_wb_mem", wb_byp, 32'h0000_0022);
    mem_reg = 1'b0;
    #1;
    check_val("rst_wb_alu", wb_nob, 32'h0000_0011);
    check_val("rst_rd_a_nobypass", rda_byp, 32'h0);
    check_val("rst_rd_b_nobypass", rdb_byp, 32'h0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset_all");

    // ALU path and memory path writes
    write_reg(5'd5, 32'hDEAD_BEEF, 1'b0);
    raddr_a = 5'd5;
    #1;
    check_val("alu_wr_r5_byp", rda_byp, 32'hDEAD_BEEF);
    check_val("alu_wr_r5_nob", rda_nob, 32'hDEAD_BEEF);
    write_reg(5'd6, 32'h1234_5678, 1'b1);
    raddr_b = 5'd6;
    #1;
    check_val("mem_wr_r6_byp", rdb_byp, 32'h1234_5678);
    check_val("mem_wr_r6_nob", rdb_nob, 32'h1234_5678);

    // write to r0 is discarded
    write_reg(5'd0, 32'hFFFF_FFFF, 1'b0);
    check_all("r0_write");

    // forwarding vs. stored value before the edge
    write_reg(5'd7, 32'h0000_0001, 1'b0);
    reg_write = 1'b1;
    waddr     = 5'd7;
    mem_reg   = 1'b0;
    alu_data  = 32'hA5A5_A5A5;
    raddr_a   = 5'd7;
    raddr_b   = 5'd7;
    #1;
    check_val("byp_r7_a", rda_byp, 32'hA5A5_A5A5);
    check_val("byp_r7_b", rdb_byp, 32'hA5A5_A5A5);
    check_val("nob_r7_a_pre", rda_nob, 32'h0000_0001);
    check_val("nob_r7_b_pre", rdb_nob, 32'h0000_0001);
    raddr_b = 5'd6;
    #1;
    check_val("byp_port_indep_b", rdb_byp, 32'h1234_5678);
    check_val("byp_port_indep_a", rda_byp, 32'hA5A5_A5A5);
    step();
    reg_write = 1'b0;
    exp_regs[7] = 32'hA5A5_A5A5;
    raddr_b = 5'd7;
    #1;
    check_val("nob_r7_a_post", rda_nob, 32'hA5A5_A5A5);
    check_val("nob_r7_b_post", rdb_nob, 32'hA5A5_A5A5);
    check_val("byp_r7_a_post", rda_byp, 32'hA5A5_A5A5);

    // reg_write=0 holds everything, including with unknown inputs
    write_reg(5'd9, 32'h0000_0077, 1'b0);
    reg_write = 1'b0;
    waddr     = 5'd9;
    alu_data  = 32'h0000_0055;
    raddr_a   = 5'd9;
    #1;
    check_val("nowr_r9_nobypass_byp", rda_byp, 32'h0000_0077);
    step(); step(); step();
    check_val("nowr_r9_byp", rda_byp, 32'h0000_0077);
    check_val("nowr_r9_nob", rda_nob, 32'h0000_0077);
    waddr    = 5'bx;
    alu_data = 32'bx;
    mem_data = 32'bx;
    step();
    check_all("x_inputs");

    // reset in the middle of a cycle with a write pending
    write_reg(5'd3, 32'hCAFE_0000, 1'b0);
    raddr_a = 5'd3;
    #1;
    check_val("r3_written", rda_nob, 32'hCAFE_0000);
    reg_write = 1'b1;
    waddr     = 5'd4;
    mem_reg   = 1'b0;
    alu_data  = 32'h0000_0044;
    raddr_b   = 5'd4;
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_r3_immediate_nob", rda_nob, 32'h0);
    check_val("rst_r3_immediate_byp", rda_byp, 32'h0);
    check_val("rst_r4_byp_suppressed", rdb_byp, 32'h0);
    check_val("rst_wb_live", wb_byp, 32'h0000_0044);
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_r4_nob", rdb_nob, 32'h0);
    check_val("post_rst_r3_nob", rda_nob, 32'h0);
    check_val("post_rst_r4_byp_fwd", rdb_byp, 32'h0000_0044);
    step();
    reg_write = 1'b0;
    exp_regs[4] = 32'h0000_0044;
    check_all("post_rst_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter: BYPASS_EN, default 1, enables same-cycle write-to-read forwarding on both read ports when 1.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 mem_read_data_buffered  input  32  load data from the MEM/WB stage.
REQ-005 alu_result_buffered  input  32  ALU result from the MEM/WB stage.
REQ-006 write_reg_addr_buffered  input  5  destination register index.
REQ-007 reg_write_buffered  input  1  write enable; 1 = commit writeback this cycle.
REQ-008 mem_reg_buffered  input  1  writeback select; 1 = memory data, 0 = ALU result.
REQ-009 read_addr_a  input  5  read port A index (rs).
REQ-010 read_addr_b  input  5  read port B index (rt).
REQ-011 read_data_a  output  32  port A data, combinational.
REQ-012 read_data_b  output  32  port B data, combinational.
REQ-013 wb_data  output  32  selected writeback value, combinational.

Function
REQ-014 wb_data SHALL equal mem_read_data_buffered when mem_reg_buffered=1, else alu_result_buffered, independent of reg_write_buffered.
REQ-015 Storage SHALL be 31 x 32-bit registers, indices 1..31; index 0 has no storage and SHALL always read 0.
REQ-016 On a clk rising edge with rst_n=1, reg_write_buffered=1 and write_reg_addr_buffered!=0, register[write_reg_addr_buffered] SHALL load wb_data; all other registers SHALL hold.
REQ-017 A write with write_reg_addr_buffered=0 SHALL be discarded, with no effect on any register.
REQ-018 With reg_write_buffered=0, no register SHALL change, whatever the address and data inputs.
REQ-019 Read ports SHALL be combinational: read_data_x = register[read_addr_x], or 0 when read_addr_x=0.
REQ-020 With BYPASS_EN=1, when reg_write_buffered=1, write_reg_addr_buffered!=0 and read_addr_x equals write_reg_addr_buffered, read_data_x SHALL equal the current wb_data in the same cycle (write-before-read).
REQ-021 With BYPASS_EN=0, read_data_x SHALL show the stored value until the clock edge; the new value SHALL appear after the edge (1-cycle write latency).
REQ-022 Ports A and B SHALL be independent: equal addresses return identical data; the bypass applies to each port separately.
REQ-023 Write latency SHALL be 1 clock edge; read latency SHALL be 0 cycles.
REQ-024 X or unknown data on inputs SHALL NOT affect any register unless the write conditions of REQ-016 hold.

Reset
REQ-025 rst_n=0 SHALL clear registers 1..31 to 32'h0000_0000 immediately, without waiting for a clock edge.
REQ-026 While rst_n=0, writes SHALL be ignored and read_data_a/read_data_b SHALL read 0 for any address; bypass SHALL be suppressed.
REQ-027 wb_data SHALL stay combinational during reset (REQ-014).
REQ-028 Reset asserted in the same cycle as a pending write SHALL discard that write; after rst_n rises, the first write SHALL occur on the next qualifying edge.
REQ-029 Deassertion of rst_n SHALL NOT alter register contents; the design SHALL be usable from the first rising edge after deassertion.

Verification
REQ-030 Reset then read all 32 addresses on both ports -> all read 0.
REQ-031 reg_write=1, mem_reg=0, alu=32'hDEAD_BEEF, addr=5, one edge; then read_addr_a=5 -> read_data_a=32'hDEAD_BEEF; mem_reg=1, mem=32'h1234_5678, addr=6 -> reg6=32'h1234_5678.
REQ-032 reg_write=1, addr=0, alu=32'hFFFF_FFFF, one edge -> read of address 0 is 0 and registers 1..31 are unchanged.
REQ-033 BYPASS_EN=1: reg7=32'h1 stored; drive write addr=7, alu=32'hA5A5_A5A5, read_addr_a=read_addr_b=7 before the edge -> both read 32'hA5A5_A5A5 in the same cycle; BYPASS_EN=0 -> both read 32'h1 until the edge.
REQ-034 reg_write=0, addr=9, alu=32'h55 over 3 edges -> reg9 keeps its prior value.
REQ-035 Write 32'hCAFE_0000 to reg3; assert rst_n=0 mid-cycle with a write to reg4 pending -> reg3 reads 0 at once, reg4 is 0 after release, and the next write to reg4 succeeds.
